// File: rtl/reg_file_if.sv
// reg_file_if: writeback-sink and dual read-port bundle for the RV32I register file.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;
  modport master (output we_i, waddr_i, wdata_i, re1_i, raddr1_i, re2_i, raddr2_i,
                  input rdata1_o, rdata2_o);
  modport slave  (input we_i, waddr_i, wdata_i, re1_i, raddr1_i, re2_i, raddr2_i,
                  output rdata1_o, rdata2_o);
endinterface

// File: rtl/reg_file.sv
// reg_file: 32x32 architectural register file, x0 hardwired to zero, async active-low reset.
// Define REGFILE_BYPASS_EN to forward the in-flight writeback to same-cycle reads.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic      clk,
  input logic      rst,
  reg_file_if.slave bus
);
  logic [DATA_W-1:0] r_regs [2**ADDR_W];
  logic              w_hit1, w_hit2;
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < 2**ADDR_W; i++) r_regs[i] <= '0;
    else if (bus.we_i && bus.waddr_i != '0)
      r_regs[bus.waddr_i] <= bus.wdata_i;
`ifdef REGFILE_BYPASS_EN
  assign w_hit1 = bus.we_i && bus.waddr_i != '0 && bus.raddr1_i == bus.waddr_i;
  assign w_hit2 = bus.we_i && bus.waddr_i != '0 && bus.raddr2_i == bus.waddr_i;
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif
  assign bus.rdata1_o = (!rst || !bus.re1_i || bus.raddr1_i == '0) ? '0 :
                        w_hit1 ? bus.wdata_i : r_regs[bus.raddr1_i];
  assign bus.rdata2_o = (!rst || !bus.re2_i || bus.raddr2_i == '0) ? '0 :
                        w_hit2 ? bus.wdata_i : r_regs[bus.raddr2_i];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: vector table, reset corner sequences and randomized traffic against an array model.
module tb_reg_file;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus();
  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic re1; logic [4:0] ra1; logic re2; logic [4:0] ra2;
    logic [31:0] e1; logic [31:0] e2;
  } vec_t;
  vec_t tv [13];
  logic [31:0] m [32];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re1, input logic [4:0] ra1, input logic re2, input logic [4:0] ra2);
    @(negedge clk);
    bus.we_i = we; bus.waddr_i = wa; bus.wdata_i = wd;
    bus.re1_i = re1; bus.raddr1_i = ra1; bus.re2_i = re2; bus.raddr2_i = ra2;
  endtask
  task automatic commit();
    @(posedge clk);
    if (!rst) foreach (m[i]) m[i] = '0;
    else if (bus.we_i && bus.waddr_i != 0) m[bus.waddr_i] = bus.wdata_i;
  endtask
  function automatic logic [31:0] model_rd(input logic re, input logic [4:0] ra);
    if (!rst || !re || ra == 0) return '0;
    if (BYP && bus.we_i && bus.waddr_i != 0 && ra == bus.waddr_i) return bus.wdata_i;
    return m[ra];
  endfunction
  initial begin
    foreach (m[i]) m[i] = '0;
    bus.we_i = 0; bus.waddr_i = 0; bus.wdata_i = 0;
    bus.re1_i = 1; bus.raddr1_i = 5; bus.re2_i = 1; bus.raddr2_i = 31;
    tv[0]  = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0, 32'h0};
    tv[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0, 32'h0};
    tv[2]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd0,  1'b0, 5'd1,  32'h0, 32'h0};
    tv[3]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd1,  1'b0, 5'd31, 32'h11, 32'h0};
    tv[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b1, 5'd31, 32'h11, 32'hFFFFFFFF};
    tv[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b0, 5'd31, 32'hFFFFFFFF, 32'h0};
    tv[6]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd1,  1'b1, 5'd31, 32'h11, 32'hFFFFFFFF};
    tv[7]  = '{1'b0, 5'd7,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    tv[8]  = '{1'b0, 5'd7,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    tv[9]  = '{1'b0, 5'd7,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    tv[10] = '{1'b1, 5'd3,  32'h1,        1'b1, 5'd7,  1'b1, 5'd1,  32'hA5A5A5A5, 32'h11};
    tv[11] = '{1'b1, 5'd3,  32'h2,        1'b1, 5'd3,  1'b1, 5'd3,
               BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1};
    tv[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b1, 5'd3,  32'h2, 32'h2};
    #2;
    chk("reset_rd1", bus.rdata1_o, 32'h0);
    chk("reset_rd2", bus.rdata2_o, 32'h0);
    #10 rst = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].re1, tv[i].ra1, tv[i].re2, tv[i].ra2);
      #1;
      chk($sformatf("vec%0d_rd1", i), bus.rdata1_o, tv[i].e1);
      chk($sformatf("vec%0d_rd2", i), bus.rdata2_o, tv[i].e2);
      commit();
    end
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    commit();
    drive(0, 0, 0, 1, 5, 1, 5);
    #1 chk("x5_written", bus.rdata1_o, 32'hDEADBEEF);
    #1 rst = 1'b0;
    foreach (m[i]) m[i] = '0;
    #1 chk("x5_during_reset", bus.rdata1_o, 32'h0);
    rst = 1'b1;
    #1 chk("x5_after_async_clear", bus.rdata1_o, 32'h0);
    chk("x31_after_async_clear", m[31] | bus.rdata2_o, 32'h0);
    drive(1, 4, 32'h99, 1, 4, 1, 4);
    rst = 1'b0;
    commit();
    @(negedge clk);
    rst = 1'b1;
    bus.we_i = 0;
    #1 chk("x4_write_in_reset", bus.rdata1_o, 32'h0);
    commit();
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, a1, a2;
      wa = (n % 3 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a1 = (n % 4 == 0) ? wa : 5'($urandom);
      a2 = (n % 5 == 0) ? wa : 5'($urandom);
      drive(1'($urandom), wa, $urandom, 1'($urandom_range(0, 3) != 0), a1,
            1'($urandom_range(0, 3) != 0), a2);
      #1;
      chk($sformatf("rand%0d_rd1", n), bus.rdata1_o, model_rd(bus.re1_i, bus.raddr1_i));
      chk($sformatf("rand%0d_rd2", n), bus.rdata2_o, model_rd(bus.re2_i, bus.raddr2_i));
      commit();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file.md
# reg_file

Architectural integer register file for the RV32I core. It sinks the writeback stream leaving the MEM/WB pipeline register and serves the two source-operand read ports of the ID stage. It holds 32 × 32-bit registers, with x0 hardwired to zero. A compile-time option adds a same-cycle write-to-read bypass.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width (2^ADDR_W registers)

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- we_i  input  1  write enable from the MEM/WB register (rd_enable)
- waddr_i  input  ADDR_W  write register index (rd_addr)
- wdata_i  input  DATA_W  write data (rd_data)
- re1_i  input  1  read port 1 enable
- raddr1_i  input  ADDR_W  read port 1 index (rs1)
- rdata1_o  output  DATA_W  read port 1 data (combinational)
- re2_i  input  1  read port 2 enable
- raddr2_i  input  ADDR_W  read port 2 index (rs2)
- rdata2_o  output  DATA_W  read port 2 data (combinational)

## Operation
- Storage: array regs[0..31] of DATA_W bits.
- Write:
  - At a rising clk edge with rst=1, we_i=1 and waddr_i≠0: regs[waddr_i] ← wdata_i.
  - Writes to x0 are dropped.
  - we_i=0 means no state change, whatever waddr_i/wdata_i hold. This covers the bubble the MEM/WB register emits on stall or reset (enable 0, addr 0, data 0).
- Read port n (n = 1, 2), evaluated combinationally and in priority order:
  - rst=0 → 0
  - re_n=0 → 0
  - raddr_n=0 → 0
  - bypass hit (see Configuration) → wdata_i
  - otherwise → regs[raddr_n]
- Both ports are independent and may name the same register. They return identical data in that case.
- Reset: asserting rst=0 clears all 32 registers to 0 immediately, without waiting for a clock edge. A write presented on the same edge that reset is held low is discarded. On deassertion, the first write is accepted at the first rising edge where rst=1.
- Arithmetic: no arithmetic is performed. Widths are exact and there is no sign extension.

## Timing
- Write latency: one edge. Data written at edge k is visible from regs on both ports immediately after edge k.
- Read latency: zero cycles (combinational from re/raddr/regs and, with bypass, from we_i/waddr_i/wdata_i).
- Reset values: all regs = 0; rdata1_o = rdata2_o = 0 while rst=0.
- Simultaneous write and read of the same index in one cycle: the result is governed by REGFILE_BYPASS_EN.
- No handshake and no stall input. Upstream guarantees that we_i is qualified.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Read port n returns wdata_i when we_i=1, waddr_i≠0, re_n=1 and raddr_n==waddr_i.
  - This removes the WB→ID hazard, so the ID stage sees the value being written this cycle.
- REGFILE_BYPASS_EN undefined:
  - Reads always return the stored regs value.
  - A same-cycle read of the register being written returns the old value. The new value is visible after the edge.
  - Hazard handling is then the forwarding/stall unit's responsibility.

## Test plan
- Reset clear: write 0xDEADBEEF to x5, then pulse rst=0 mid-cycle. Expect rdata1_o=0 during reset. After release, expect reading x5 → 0x00000000 with no clock edge needed for the clear.
- x0 hardwired: we_i=1, waddr_i=0, wdata_i=0x12345678, clock once. Expect reading x0 on both ports → 0.
- Basic write/read: write x1=0x00000011, then x31=0xFFFFFFFF on consecutive edges. Expect rs1=x1 → 0x11 and rs2=x31 → 0xFFFFFFFF. With re2_i=0, expect rdata2_o=0.
- Bubble ignored: x7=0xA5A5A5A5 stored; drive we_i=0, waddr_i=7, wdata_i=0 for 3 edges. Expect x7 to still read 0xA5A5A5A5.
- Same-cycle hazard: x3=0x1 stored; in one cycle drive we_i=1, waddr_i=3, wdata_i=0x2 and read x3 on both ports before the edge.
  - With REGFILE_BYPASS_EN: expect 0x2.
  - Without it: expect 0x1.
  - After the edge, expect 0x2 in both builds.
- Write during reset: hold rst=0 with we_i=1, waddr_i=4, wdata_i=0x99 across an edge, then release. Expect x4 → 0.
